// File: rtl/axis_spi_cmd_ctrl.sv
// axis_spi_cmd_ctrl: turns SPI command frames into 8-bit register bus writes and reads.
// Define AXIS_SPI_CMD_AUTOINC_EN for burst addressing; the default build keeps a fixed FIFO-port address.
module axis_spi_cmd_ctrl #(
   parameter int MAX_LEN = 64
) (
   input  logic       axis_aclk,
   input  logic       axis_areset,
   input  logic [7:0] s_axis_tdata,
   input  logic       s_axis_tvalid,
   output logic       s_axis_tready,
   input  logic       s_axis_tlast,
   output logic [7:0] m_axis_tdata,
   output logic       m_axis_tvalid,
   input  logic       m_axis_tready,
   output logic       m_axis_tlast,
   output logic       m_axis_tkeep,
   output logic       m_axis_tuser,
   output logic [7:0] reg_addr,
   output logic [7:0] reg_wdata,
   output logic       reg_we,
   output logic       reg_re,
   input  logic [7:0] reg_rdata,
   output logic       busy,
   output logic       frame_err
);
   localparam int CW = $clog2(MAX_LEN + 1);
`ifdef AXIS_SPI_CMD_AUTOINC_EN
   localparam logic [7:0] ADDR_INC = 8'd1;
`else
   localparam logic [7:0] ADDR_INC = 8'd0;
`endif
   typedef enum logic [2:0] {IDLE, ADDR, WDATA, RFETCH, RLOAD, RSEND, DRAIN} state_t;
   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [7:0]    addr_q, addr_d, raddr_q, raddr_d, wdata_q, wdata_d, tdata_q, tdata_d;
   logic          rd_q, rd_d, we_q, we_d, err_q, err_d, tlast_q, tlast_d, rdy_q;
   logic          rx_hs, rx_end, tx_hs, tx_valid, in_read;

   assign rx_hs   = s_axis_tvalid & rdy_q;
   assign rx_end  = rx_hs & s_axis_tlast;
   assign tx_hs   = tx_valid & m_axis_tready;
   assign in_read = state_q inside {RFETCH, RLOAD, RSEND};

   always_ff @(posedge axis_aclk or posedge axis_areset) begin
      if (axis_areset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         raddr_q <= '0;
         wdata_q <= '0;
         tdata_q <= '0;
         rd_q    <= 1'b0;
         we_q    <= 1'b0;
         err_q   <= 1'b0;
         tlast_q <= 1'b0;
         rdy_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         raddr_q <= raddr_d;
         wdata_q <= wdata_d;
         tdata_q <= tdata_d;
         rd_q    <= rd_d;
         we_q    <= we_d;
         err_q   <= err_d;
         tlast_q <= tlast_d;
         rdy_q   <= 1'b1;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      raddr_d = raddr_q;
      wdata_d = wdata_q;
      tdata_d = tdata_q;
      rd_d    = rd_q;
      tlast_d = tlast_q;
      we_d    = 1'b0;
      err_d   = 1'b0;
      case (state_q)
         IDLE: if (rx_hs) begin
            rd_d    = s_axis_tdata[7];
            cnt_d   = CW'(s_axis_tdata[5:0]) + CW'(1);
            err_d   = s_axis_tlast;
            state_d = s_axis_tlast ? IDLE : ADDR;
         end
         ADDR: if (rx_hs) begin
            addr_d  = s_axis_tdata;
            raddr_d = s_axis_tdata;
            err_d   = s_axis_tlast;
            state_d = s_axis_tlast ? IDLE : (rd_q ? RFETCH : WDATA);
         end
         WDATA: if (rx_hs) begin
            we_d    = 1'b1;
            raddr_d = addr_q;
            wdata_d = s_axis_tdata;
            addr_d  = addr_q + ADDR_INC;
            cnt_d   = cnt_q - CW'(1);
            err_d   = s_axis_tlast && cnt_q != CW'(1);
            state_d = s_axis_tlast ? IDLE : (cnt_q == CW'(1) ? DRAIN : WDATA);
         end
         RFETCH: state_d = RLOAD;
         RLOAD: begin
            tdata_d = reg_rdata;
            tlast_d = cnt_q == CW'(1);
            state_d = RSEND;
         end
         RSEND: if (tx_hs) begin
            cnt_d   = cnt_q - CW'(1);
            addr_d  = addr_q + ADDR_INC;
            raddr_d = addr_q + ADDR_INC;
            state_d = cnt_q == CW'(1) ? DRAIN : RFETCH;
         end
         DRAIN: if (rx_end) state_d = IDLE;
         default: state_d = IDLE;
      endcase
      // CS released mid-read: drop any pending TX byte, only a just-sent final byte completes the frame
      if (rx_end && in_read) begin
         state_d = IDLE;
         err_d   = !(state_q == RSEND && tx_hs && cnt_q == CW'(1));
      end
   end

   always_comb begin
      tx_valid = state_q == RSEND;
      reg_re   = state_q == RFETCH;
      busy     = state_q != IDLE;
   end

   assign s_axis_tready = rdy_q;
   assign m_axis_tdata  = tdata_q;
   assign m_axis_tvalid = tx_valid;
   assign m_axis_tlast  = tlast_q;
   assign m_axis_tkeep  = 1'b1;
   assign m_axis_tuser  = 1'b0;
   assign reg_addr      = raddr_q;
   assign reg_wdata     = wdata_q;
   assign reg_we        = we_q;
   assign frame_err     = err_q;
endmodule
